// File: rtl/riscv_vec_dmem_arbiter.sv
// Round-robin merge of four vector-lane data-memory ports onto one memory port.
// A tag FIFO of granted lane indices steers in-order responses back to their lane.
module riscv_vec_dmem_arbiter #(
    parameter int p_max_out = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [66:0] lreq_msg_0,
    input  logic [66:0] lreq_msg_1,
    input  logic [66:0] lreq_msg_2,
    input  logic [66:0] lreq_msg_3,
    input  logic        lreq_val_0,
    input  logic        lreq_val_1,
    input  logic        lreq_val_2,
    input  logic        lreq_val_3,
    output logic        lreq_rdy_0,
    output logic        lreq_rdy_1,
    output logic        lreq_rdy_2,
    output logic        lreq_rdy_3,

    output logic [34:0] lresp_msg_0,
    output logic [34:0] lresp_msg_1,
    output logic [34:0] lresp_msg_2,
    output logic [34:0] lresp_msg_3,
    output logic        lresp_val_0,
    output logic        lresp_val_1,
    output logic        lresp_val_2,
    output logic        lresp_val_3,

    output logic [66:0] memreq_msg,
    output logic        memreq_val,
    input  logic        memreq_rdy,

    input  logic [34:0] memresp_msg,
    input  logic        memresp_val,

    output logic        err
);

    localparam int AW = $clog2(p_max_out);
    localparam int CW = AW + 1;

    logic [66:0]   req_msg [4];
    logic [3:0]    req_val;
    logic [3:0]    req_rdy;
    logic [3:0]    resp_val;

    logic [1:0]    ptr_reg, ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          err_reg, err_next;
    logic [1:0]    tag_mem [p_max_out];

    logic [1:0]    gnt;
    logic [1:0]    head;
    logic          any_val;
    logic          full;
    logic          empty;
    logic          fire;
    logic          pop;
    logic          spurious;

    assign req_msg[0] = lreq_msg_0;
    assign req_msg[1] = lreq_msg_1;
    assign req_msg[2] = lreq_msg_2;
    assign req_msg[3] = lreq_msg_3;
    assign req_val    = {lreq_val_3, lreq_val_2, lreq_val_1, lreq_val_0};

    // First valid lane at or after the round-robin pointer.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        gnt   = ptr_reg;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_reg + k[1:0];
            if (!found && req_val[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_val  = |req_val;
    assign full     = (count_reg == CW'(p_max_out));
    assign empty    = (count_reg == '0);
    assign head     = tag_mem[rd_ptr_reg];

    // Reset gating keeps every handshake quiet while reset is held low.
    assign memreq_val = reset & any_val & ~full;
    assign memreq_msg = req_msg[gnt];
    assign fire       = memreq_val & memreq_rdy;
    assign pop        = reset & memresp_val & ~empty;
    assign spurious   = reset & memresp_val & empty;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign req_rdy[gi]  = fire & (gnt == 2'(gi));
            assign resp_val[gi] = pop & (head == 2'(gi));
        end
    endgenerate

    assign lreq_rdy_0  = req_rdy[0];
    assign lreq_rdy_1  = req_rdy[1];
    assign lreq_rdy_2  = req_rdy[2];
    assign lreq_rdy_3  = req_rdy[3];
    assign lresp_val_0 = resp_val[0];
    assign lresp_val_1 = resp_val[1];
    assign lresp_val_2 = resp_val[2];
    assign lresp_val_3 = resp_val[3];
    assign lresp_msg_0 = memresp_msg;
    assign lresp_msg_1 = memresp_msg;
    assign lresp_msg_2 = memresp_msg;
    assign lresp_msg_3 = memresp_msg;
    assign err         = err_reg;

    always_comb begin
        ptr_next    = ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg | spurious;
        if (fire) begin
            ptr_next    = gnt + 2'd1;
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({fire, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    // Tag storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr_reg] <= gnt;
        end
    end

endmodule

// File: tb/tb_riscv_vec_dmem_arbiter.sv
// Directed bench for riscv_vec_dmem_arbiter: arbitration order, FIFO full/steering,
// spurious responses and asynchronous reset.
module tb_riscv_vec_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [66:0] lreq_msg [4];
    logic [3:0]  lreq_val;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;

    logic        lreq_rdy_0, lreq_rdy_1, lreq_rdy_2, lreq_rdy_3;
    logic        lresp_val_0, lresp_val_1, lresp_val_2, lresp_val_3;
    logic [34:0] lresp_msg_0, lresp_msg_1, lresp_msg_2, lresp_msg_3;
    logic [66:0] memreq_msg;
    logic        memreq_val;
    logic        err;

    logic [3:0]  rdy;
    logic [3:0]  rval;
    logic [34:0] rmsg [4];

    int n_checks = 0;
    int n_fail   = 0;

    assign rdy     = {lreq_rdy_3, lreq_rdy_2, lreq_rdy_1, lreq_rdy_0};
    assign rval    = {lresp_val_3, lresp_val_2, lresp_val_1, lresp_val_0};
    assign rmsg[0] = lresp_msg_0;
    assign rmsg[1] = lresp_msg_1;
    assign rmsg[2] = lresp_msg_2;
    assign rmsg[3] = lresp_msg_3;

    riscv_vec_dmem_arbiter #(.p_max_out(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .lreq_msg_0  (lreq_msg[0]),
        .lreq_msg_1  (lreq_msg[1]),
        .lreq_msg_2  (lreq_msg[2]),
        .lreq_msg_3  (lreq_msg[3]),
        .lreq_val_0  (lreq_val[0]),
        .lreq_val_1  (lreq_val[1]),
        .lreq_val_2  (lreq_val[2]),
        .lreq_val_3  (lreq_val[3]),
        .lreq_rdy_0  (lreq_rdy_0),
        .lreq_rdy_1  (lreq_rdy_1),
        .lreq_rdy_2  (lreq_rdy_2),
        .lreq_rdy_3  (lreq_rdy_3),
        .lresp_msg_0 (lresp_msg_0),
        .lresp_msg_1 (lresp_msg_1),
        .lresp_msg_2 (lresp_msg_2),
        .lresp_msg_3 (lresp_msg_3),
        .lresp_val_0 (lresp_val_0),
        .lresp_val_1 (lresp_val_1),
        .lresp_val_2 (lresp_val_2),
        .lresp_val_3 (lresp_val_3),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane_addr(input int i);
        return 32'h1000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [66:0] mk_req(input logic [31:0] a);
        return {1'b0, a, 2'b00, 32'h0};
    endfunction

    function automatic logic [34:0] mk_resp(input logic [31:0] d);
        return {1'b0, 2'b00, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic mrdy, input logic rv, input logic [31:0] rdata);
        lreq_val    = v;
        memreq_rdy  = mrdy;
        memresp_val = rv;
        memresp_msg = mk_resp(rdata);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) lreq_msg[i] = mk_req(lane_addr(i));
        lreq_val    = 4'hF;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(32'hDEAD);
        #3;
        n_checks++;
        if (rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0000", rdy); end
        n_checks++;
        if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL reset_memreq_val got=%b exp=0", memreq_val); end
        n_checks++;
        if (rval !== 4'b0000) begin n_fail++; $display("FAIL reset_lresp_val got=%b exp=0000", rval); end
        tick();
        tick();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        drive(4'h0, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_r;
        for (int c = 0; c < 7; c++) begin
            drive((c < 6) ? 4'hF : 4'h0, 1'b1, (c >= 1), (c >= 1) ? lane_addr((c + 3) % 4) : 32'h0);
            if (c < 6) begin
                exp_g = 4'b0001 << (c % 4);
                n_checks++;
                if (rdy !== exp_g) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, rdy, exp_g); end
                n_checks++;
                if (memreq_msg !== mk_req(lane_addr(c % 4))) begin
                    n_fail++; $display("FAIL rr_memreq_msg c=%0d got=%h exp=%h", c, memreq_msg, mk_req(lane_addr(c % 4)));
                end
            end
            if (c >= 1) begin
                exp_r = 4'b0001 << ((c - 1) % 4);
                n_checks++;
                if (rval !== exp_r) begin n_fail++; $display("FAIL rr_lresp_val c=%0d got=%b exp=%b", c, rval, exp_r); end
                n_checks++;
                if (rmsg[(c - 1) % 4][31:0] !== lane_addr((c - 1) % 4)) begin
                    n_fail++; $display("FAIL rr_lresp_data c=%0d got=%h exp=%h", c, rmsg[(c - 1) % 4][31:0], lane_addr((c - 1) % 4));
                end
            end
            $display("rr cycle %0d rdy=%b lresp_val=%b", c, rdy, rval);
            tick();
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 4; c++) begin
            drive(4'b0100, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (rdy !== 4'b0100) begin n_fail++; $display("FAIL full_fill c=%0d got=%b exp=0100", c, rdy); end
            tick();
        end
        drive(4'b0100, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL full_memreq_val got=%b exp=0", memreq_val); end
        n_checks++;
        if (rdy !== 4'b0000) begin n_fail++; $display("FAIL full_rdy got=%b exp=0000", rdy); end
        tick();
        drive(4'b0100, 1'b1, 1'b1, 32'h2200);
        n_checks++;
        if (rval !== 4'b0100) begin n_fail++; $display("FAIL full_pop_lresp got=%b exp=0100", rval); end
        n_checks++;
        if (rdy !== 4'b0000) begin n_fail++; $display("FAIL full_pop_blocks_push got=%b exp=0000", rdy); end
        tick();
        drive(4'b0100, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b0100) begin n_fail++; $display("FAIL full_regrant got=%b exp=0100", rdy); end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(4'b0000, 1'b1, 1'b1, 32'h2300 + 32'(c));
            n_checks++;
            if (rval !== 4'b0100) begin n_fail++; $display("FAIL full_drain c=%0d got=%b exp=0100", c, rval); end
            tick();
        end
        $display("full test done");
    endtask

    task automatic test_back_pressure();
        // Lone lane-3 request moves the pointer to 0 before the stall.
        drive(4'b1000, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b1000) begin n_fail++; $display("FAIL bp_pre_grant got=%b exp=1000", rdy); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h3300);
        n_checks++;
        if (rval !== 4'b1000) begin n_fail++; $display("FAIL bp_pre_resp got=%b exp=1000", rval); end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1001, 1'b0, 1'b0, 32'h0);
            n_checks++;
            if (rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_rdy c=%0d got=%b exp=0000", c, rdy); end
            n_checks++;
            if (memreq_val !== 1'b1 || memreq_msg !== mk_req(lane_addr(0))) begin
                n_fail++; $display("FAIL bp_stall_req c=%0d got=%b/%h exp=1/%h", c, memreq_val, memreq_msg, mk_req(lane_addr(0)));
            end
            tick();
        end
        drive(4'b1001, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b0001) begin n_fail++; $display("FAIL bp_release_0 got=%b exp=0001", rdy); end
        tick();
        drive(4'b1001, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b1000) begin n_fail++; $display("FAIL bp_release_3 got=%b exp=1000", rdy); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h1000);
        n_checks++;
        if (rval !== 4'b0001) begin n_fail++; $display("FAIL bp_drain_0 got=%b exp=0001", rval); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h1300);
        n_checks++;
        if (rval !== 4'b1000) begin n_fail++; $display("FAIL bp_drain_3 got=%b exp=1000", rval); end
        tick();
        $display("back-pressure test done");
    endtask

    task automatic test_push_pop();
        drive(4'b1000, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b1000) begin n_fail++; $display("FAIL pp_fill_3 got=%b exp=1000", rdy); end
        tick();
        drive(4'b0001, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b0001) begin n_fail++; $display("FAIL pp_fill_0 got=%b exp=0001", rdy); end
        tick();
        drive(4'b0010, 1'b1, 1'b1, 32'h1300);
        n_checks++;
        if (rdy !== 4'b0010) begin n_fail++; $display("FAIL pp_push_1 got=%b exp=0010", rdy); end
        n_checks++;
        if (rval !== 4'b1000) begin n_fail++; $display("FAIL pp_pop_3 got=%b exp=1000", rval); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h1000);
        n_checks++;
        if (rval !== 4'b0001) begin n_fail++; $display("FAIL pp_next_0 got=%b exp=0001", rval); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h1100);
        n_checks++;
        if (rval !== 4'b0010) begin n_fail++; $display("FAIL pp_tail_1 got=%b exp=0010", rval); end
        tick();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL pp_err got=%b exp=0", err); end
        $display("push/pop test done");
    endtask

    task automatic test_spurious();
        drive(4'b0000, 1'b1, 1'b1, 32'hBAD0);
        n_checks++;
        if (rval !== 4'b0000) begin n_fail++; $display("FAIL spur_lresp got=%b exp=0000", rval); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL spur_err_before got=%b exp=0", err); end
        tick();
        drive(4'b0000, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_set got=%b exp=1", err); end
        tick();
        tick();
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_hold got=%b exp=1", err); end
        $display("spurious test done");
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_g;
        // Pointer starts at 2 here: grants 2,3,0 leave it at 1.
        for (int c = 0; c < 3; c++) begin
            drive(4'hF, 1'b1, 1'b0, 32'h0);
            exp_g = 4'b0001 << ((c + 2) % 4);
            n_checks++;
            if (rdy !== exp_g) begin n_fail++; $display("FAIL rm_fill c=%0d got=%b exp=%b", c, rdy, exp_g); end
            tick();
        end
        drive(4'hF, 1'b1, 1'b1, 32'h1200);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (rdy !== 4'b0000 || memreq_val !== 1'b0) begin
            n_fail++; $display("FAIL rm_async_req got=%b/%b exp=0000/0", rdy, memreq_val);
        end
        n_checks++;
        if (rval !== 4'b0000 || err !== 1'b0) begin
            n_fail++; $display("FAIL rm_async_resp got=%b/%b exp=0000/0", rval, err);
        end
        tick();
        n_checks++;
        if (rdy !== 4'b0000 || rval !== 4'b0000 || memreq_val !== 1'b0) begin
            n_fail++; $display("FAIL rm_held got=%b/%b/%b exp=0000/0000/0", rdy, rval, memreq_val);
        end
        reset = 1'b1;
        drive(4'b0101, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (rdy !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant got=%b exp=0001", rdy); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h1000);
        n_checks++;
        if (rval !== 4'b0001) begin n_fail++; $display("FAIL rm_new_resp got=%b exp=0001", rval); end
        tick();
        drive(4'b0000, 1'b1, 1'b1, 32'h1200);
        n_checks++;
        if (rval !== 4'b0000 || err !== 1'b0) begin
            n_fail++; $display("FAIL rm_stale_resp got=%b/%b exp=0000/0", rval, err);
        end
        tick();
        drive(4'b0000, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL rm_stale_err got=%b exp=1", err); end
        $display("reset mid-operation test done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full();
        test_back_pressure();
        test_push_pop();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
